// File: rtl/fir_mdc_package.sv
// Shared types and defaults for the FIR MDC job scheduler.
// Holds the scheduler state encoding and the job descriptor layout.
package fir_mdc_package;

    localparam int unsigned AW_DEF  = 32;
    localparam int unsigned CW_DEF  = 16;
    localparam int unsigned IDW_DEF = 4;

    typedef enum logic [2:0] {
        SCHED_IDLE,
        SCHED_LAUNCH,
        SCHED_START,
        SCHED_RUN,
        SCHED_ABORT,
        SCHED_GAP
    } sched_state_t;

    typedef struct packed {
        logic [AW_DEF-1:0]  x_addr;
        logic [AW_DEF-1:0]  y_addr;
        logic [CW_DEF-1:0]  cnt_limit;
        logic [IDW_DEF-1:0] id;
    } job_desc_t;

endpackage

// File: rtl/fir_mdc_job_fifo.sv
// Job descriptor FIFO: DEPTH entries of DW bits, with occupancy level.
// Ports: push_i/data_i/ready_o in, pop_i/data_o out, level_o, sync clear_i.
module fir_mdc_job_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 84
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [DW-1:0]            data_i,
    output logic                     ready_o,
    input  logic                     pop_i,
    output logic [DW-1:0]            data_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop;

    // Ready comes from the registered level only, so a full FIFO
    // never accepts a push even in a pop cycle.
    assign ready_o = (level_q != LW'(DEPTH));
    assign push    = push_i & ready_o;
    assign pop     = pop_i & (level_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign level_o = level_q;

    always_comb begin
        wptr_d  = wptr_q + PW'(push);
        rptr_d  = rptr_q + PW'(pop);
        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clear_i) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/fir_mdc_job_sched.sv
// Job scheduler in front of the FIR MDC HWPE: queues descriptors, launches
// them one by one, and aborts overrunning jobs through a watchdog.
// Ports: push_* descriptor input, job_* active job, job_start_o/job_done_i
// engine handshake, hwpe_clear_o abort flush, evt_* completion, busy/level.
module fir_mdc_job_sched
    import fir_mdc_package::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned CW    = CW_DEF,
    parameter int unsigned IDW   = IDW_DEF,
    parameter int unsigned TMO_W = 20
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   push_valid_i,
    output logic                   push_ready_o,
    input  logic [AW-1:0]          push_x_addr_i,
    input  logic [AW-1:0]          push_y_addr_i,
    input  logic [CW-1:0]          push_cnt_limit_i,
    input  logic [IDW-1:0]         push_id_i,
    input  logic [TMO_W-1:0]       tmo_limit_i,
    output logic [AW-1:0]          job_x_addr_o,
    output logic [AW-1:0]          job_y_addr_o,
    output logic [CW-1:0]          job_cnt_limit_o,
    output logic                   job_start_o,
    input  logic                   job_done_i,
    output logic                   hwpe_clear_o,
    output logic                   evt_o,
    output logic [IDW-1:0]         evt_id_o,
    output logic                   evt_err_o,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned DW = 2 * AW + CW + IDW;

    sched_state_t     state_q;
    logic [DW-1:0]    push_data, head;
    logic [IDW-1:0]   job_id_q;
    logic [TMO_W-1:0] wdog_q, wdog_inc;
    logic             pop, tmo_hit;

    assign push_data = {push_x_addr_i, push_y_addr_i,
                        push_cnt_limit_i, push_id_i};
    assign pop       = (state_q == SCHED_LAUNCH);

    fir_mdc_job_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push_valid_i),
        .data_i  (push_data),
        .ready_o (push_ready_o),
        .pop_i   (pop),
        .data_o  (head),
        .level_o (level_o)
    );

    // The watchdog counts cycles since the start pulse and saturates.
    assign wdog_inc = (&wdog_q) ? wdog_q : wdog_q + TMO_W'(1);
    assign tmo_hit  = (tmo_limit_i != '0) &&
                      (wdog_q == tmo_limit_i - TMO_W'(1));
    assign busy_o   = (state_q != SCHED_IDLE) | (level_o != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= SCHED_IDLE;
            job_x_addr_o    <= '0;
            job_y_addr_o    <= '0;
            job_cnt_limit_o <= '0;
            job_id_q        <= '0;
            wdog_q          <= '0;
            job_start_o     <= 1'b0;
            hwpe_clear_o    <= 1'b0;
            evt_o           <= 1'b0;
            evt_id_o        <= '0;
            evt_err_o       <= 1'b0;
        end else begin
            job_start_o  <= 1'b0;
            hwpe_clear_o <= 1'b0;
            evt_o        <= 1'b0;
            evt_id_o     <= '0;
            evt_err_o    <= 1'b0;
            if (clear_i) begin
                // Flush the engine only if it may be running a job.
                hwpe_clear_o    <= (state_q == SCHED_START) ||
                                   (state_q == SCHED_RUN);
                state_q         <= SCHED_IDLE;
                job_x_addr_o    <= '0;
                job_y_addr_o    <= '0;
                job_cnt_limit_o <= '0;
                job_id_q        <= '0;
                wdog_q          <= '0;
            end else begin
                unique case (state_q)
                    SCHED_IDLE: begin
                        if (level_o != '0) state_q <= SCHED_LAUNCH;
                    end
                    SCHED_LAUNCH: begin
                        job_x_addr_o    <= head[DW-1 -: AW];
                        job_y_addr_o    <= head[DW-AW-1 -: AW];
                        job_cnt_limit_o <= head[CW+IDW-1 -: CW];
                        job_id_q        <= head[IDW-1:0];
                        wdog_q          <= '0;
                        job_start_o     <= 1'b1;
                        state_q         <= SCHED_START;
                    end
                    SCHED_START: begin
                        wdog_q  <= wdog_inc;
                        state_q <= SCHED_RUN;
                    end
                    SCHED_RUN: begin
                        wdog_q <= wdog_inc;
                        // Done takes priority over a coinciding timeout.
                        if (job_done_i) begin
                            evt_o    <= 1'b1;
                            evt_id_o <= job_id_q;
                            state_q  <= SCHED_GAP;
                        end else if (tmo_hit) begin
                            hwpe_clear_o <= 1'b1;
                            state_q      <= SCHED_ABORT;
                        end
                    end
                    SCHED_ABORT: begin
                        evt_o     <= 1'b1;
                        evt_id_o  <= job_id_q;
                        evt_err_o <= 1'b1;
                        state_q   <= SCHED_GAP;
                    end
                    SCHED_GAP: begin
                        state_q <= SCHED_IDLE;
                    end
                    default: begin
                        state_q <= SCHED_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_mdc_job_sched.sv
// Self-checking bench for fir_mdc_job_sched: random jobs and latencies
// compared against a cycle-arithmetic model of the scheduling rules.
module tb_fir_mdc_job_sched;
    import fir_mdc_package::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int CW    = 16;
    localparam int IDW   = 4;
    localparam int TMO_W = 20;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             clear_i;
    logic             push_valid_i;
    logic             push_ready_o;
    logic [AW-1:0]    push_x_addr_i;
    logic [AW-1:0]    push_y_addr_i;
    logic [CW-1:0]    push_cnt_limit_i;
    logic [IDW-1:0]   push_id_i;
    logic [TMO_W-1:0] tmo_limit_i;
    logic [AW-1:0]    job_x_addr_o;
    logic [AW-1:0]    job_y_addr_o;
    logic [CW-1:0]    job_cnt_limit_o;
    logic             job_start_o;
    logic             job_done_i;
    logic             hwpe_clear_o;
    logic             evt_o;
    logic [IDW-1:0]   evt_id_o;
    logic             evt_err_o;
    logic             busy_o;
    logic [2:0]       level_o;

    fir_mdc_job_sched #(
        .DEPTH(DEPTH), .AW(AW), .CW(CW), .IDW(IDW), .TMO_W(TMO_W)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .push_x_addr_i(push_x_addr_i), .push_y_addr_i(push_y_addr_i),
        .push_cnt_limit_i(push_cnt_limit_i), .push_id_i(push_id_i),
        .tmo_limit_i(tmo_limit_i),
        .job_x_addr_o(job_x_addr_o), .job_y_addr_o(job_y_addr_o),
        .job_cnt_limit_o(job_cnt_limit_o), .job_start_o(job_start_o),
        .job_done_i(job_done_i), .hwpe_clear_o(hwpe_clear_o),
        .evt_o(evt_o), .evt_id_o(evt_id_o), .evt_err_o(evt_err_o),
        .busy_o(busy_o), .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          c;
        logic [31:0] x;
        logic [31:0] y;
        logic [15:0] lim;
    } st_rec_t;

    typedef struct {
        int         c;
        logic [3:0] id;
        logic       err;
    } ev_rec_t;

    int        cyc;
    int        n_chk;
    int        n_pass;
    st_rec_t   st_q[$];
    ev_rec_t   ev_q[$];
    int        hc_q[$];
    int        lat_q[$];
    int        done_q[$];
    job_desc_t jd_q[$];
    int        jp_q[$];
    int        jl_q[$];

    // One cycle: sample outputs at the falling edge, answer starts with a
    // done pulse lat cycles later (lat 0 = engine never finishes).
    task automatic step();
        int l;
        @(negedge clk_i);
        cyc++;
        if (job_start_o === 1'b1) begin
            st_q.push_back('{cyc, job_x_addr_o, job_y_addr_o,
                             job_cnt_limit_o});
            if (lat_q.size() > 0) begin
                l = lat_q.pop_front();
                if (l > 0) done_q.push_back(cyc + l);
            end
        end
        if (evt_o === 1'b1) ev_q.push_back('{cyc, evt_id_o, evt_err_o});
        if (hwpe_clear_o === 1'b1) hc_q.push_back(cyc);
        job_done_i = 1'b0;
        foreach (done_q[i]) if (done_q[i] == cyc) job_done_i = 1'b1;
    endtask

    task automatic clear_recs();
        st_q.delete(); ev_q.delete(); hc_q.delete();
        lat_q.delete(); done_q.delete();
        jd_q.delete(); jp_q.delete(); jl_q.delete();
    endtask

    function automatic job_desc_t rand_job(input int id);
        job_desc_t jd;
        jd.x_addr    = $urandom;
        jd.y_addr    = $urandom;
        jd.cnt_limit = 16'($urandom_range(1, 65535));
        jd.id        = 4'(id);
        return jd;
    endfunction

    task automatic do_push(input job_desc_t jd, input int lat,
                           output int acc);
        int k;
        k = 0;
        push_x_addr_i    = jd.x_addr;
        push_y_addr_i    = jd.y_addr;
        push_cnt_limit_i = jd.cnt_limit;
        push_id_i        = jd.id;
        push_valid_i     = 1'b1;
        while (push_ready_o !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) begin
            n_chk++;
            $display("FAIL push_timeout: ready stayed %b, want 1",
                     push_ready_o);
        end
        acc = cyc;
        jd_q.push_back(jd);
        jp_q.push_back(acc);
        jl_q.push_back(lat);
        lat_q.push_back(lat);
        step();
        push_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy_o !== 1'b0 && k < 400) begin
            step();
            k++;
        end
        n_chk++;
        if (busy_o !== 1'b0)
            $display("FAIL %s_idle: busy %b want 0", tag, busy_o);
        else n_pass++;
        step();
    endtask

    // Reference: a job present from the cycle after its push launches at
    // the first free IDLE cycle, starts 2 cycles later, finishes on done or
    // aborts at start+tmo, and frees the scheduler 2 cycles after its event.
    task automatic check_model(input int t0, input int tmo,
                               input string tag);
        int   free, c, s, l;
        int   est[$];
        int   eev[$];
        logic eerr[$];
        int   ehc[$];
        bit   stuck;
        free  = t0;
        stuck = 0;
        for (int j = 0; j < jd_q.size(); j++) begin
            if (!stuck) begin
                c = (free > jp_q[j] + 1) ? free : jp_q[j] + 1;
                s = c + 2;
                est.push_back(s);
                l = jl_q[j];
                if (l != 0 && (tmo == 0 || l <= tmo - 1)) begin
                    eev.push_back(s + l + 1);
                    eerr.push_back(1'b0);
                    free = s + l + 2;
                end else if (tmo != 0) begin
                    ehc.push_back(s + tmo);
                    eev.push_back(s + tmo + 1);
                    eerr.push_back(1'b1);
                    free = s + tmo + 2;
                end else begin
                    stuck = 1;
                end
            end
        end
        n_chk++;
        if (st_q.size() !== est.size())
            $display("FAIL %s_nstart: got %0d want %0d",
                     tag, st_q.size(), est.size());
        else n_pass++;
        for (int j = 0; j < est.size() && j < st_q.size(); j++) begin
            n_chk++;
            if (st_q[j].c !== est[j])
                $display("FAIL %s_start%0d_cyc: got %0d want %0d",
                         tag, j, st_q[j].c, est[j]);
            else n_pass++;
            n_chk++;
            if (st_q[j].x !== jd_q[j].x_addr ||
                st_q[j].y !== jd_q[j].y_addr ||
                st_q[j].lim !== jd_q[j].cnt_limit)
                $display("FAIL %s_job%0d: got %h/%h/%h want %h/%h/%h",
                         tag, j, st_q[j].x, st_q[j].y, st_q[j].lim,
                         jd_q[j].x_addr, jd_q[j].y_addr,
                         jd_q[j].cnt_limit);
            else n_pass++;
        end
        n_chk++;
        if (ev_q.size() !== eev.size())
            $display("FAIL %s_nevt: got %0d want %0d",
                     tag, ev_q.size(), eev.size());
        else n_pass++;
        for (int j = 0; j < eev.size() && j < ev_q.size(); j++) begin
            n_chk++;
            if (ev_q[j].c !== eev[j] || ev_q[j].id !== jd_q[j].id ||
                ev_q[j].err !== eerr[j])
                $display("FAIL %s_evt%0d: got c%0d id%0d e%b want c%0d id%0d e%b",
                         tag, j, ev_q[j].c, ev_q[j].id, ev_q[j].err,
                         eev[j], jd_q[j].id, eerr[j]);
            else n_pass++;
        end
        n_chk++;
        if (hc_q.size() !== ehc.size())
            $display("FAIL %s_nclr: got %0d want %0d",
                     tag, hc_q.size(), ehc.size());
        else n_pass++;
        for (int j = 0; j < ehc.size() && j < hc_q.size(); j++) begin
            n_chk++;
            if (hc_q[j] !== ehc[j])
                $display("FAIL %s_clr%0d_cyc: got %0d want %0d",
                         tag, j, hc_q[j], ehc[j]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clear_i = 1'b0; push_valid_i = 1'b0;
        push_x_addr_i = '0; push_y_addr_i = '0;
        push_cnt_limit_i = '0; push_id_i = '0;
        tmo_limit_i = '0; job_done_i = 1'b0;
        repeat (3) step();
        rst_ni = 1'b1;
        step();
        n_chk++;
        if (push_ready_o !== 1'b1)
            $display("FAIL rst_ready: got %b want 1", push_ready_o);
        else n_pass++;
        n_chk++;
        if ({job_start_o, hwpe_clear_o, evt_o, evt_err_o, busy_o} !== 5'b0)
            $display("FAIL rst_pulses: got %b want 00000",
                     {job_start_o, hwpe_clear_o, evt_o, evt_err_o, busy_o});
        else n_pass++;
        n_chk++;
        if (level_o !== 3'd0)
            $display("FAIL rst_level: got %0d want 0", level_o);
        else n_pass++;
        n_chk++;
        if (job_x_addr_o !== '0 || job_y_addr_o !== '0 ||
            job_cnt_limit_o !== '0 || evt_id_o !== '0)
            $display("FAIL rst_job: got %h/%h/%h/%h want 0",
                     job_x_addr_o, job_y_addr_o, job_cnt_limit_o, evt_id_o);
        else n_pass++;
    endtask

    task automatic test_single();
        job_desc_t jd;
        int        t0, p;
        clear_recs();
        tmo_limit_i = '0;
        t0 = cyc;
        jd.x_addr = 32'h1000; jd.y_addr = 32'h2000;
        jd.cnt_limit = 16'd8; jd.id = 4'd3;
        do_push(jd, 20, p);
        while (cyc < p + 24) step();
        n_chk++;
        if (busy_o !== 1'b1)
            $display("FAIL single_busy_gap: got %b want 1", busy_o);
        else n_pass++;
        step();
        n_chk++;
        if (busy_o !== 1'b0)
            $display("FAIL single_busy_idle: got %b want 0", busy_o);
        else n_pass++;
        repeat (5) step();
        check_model(t0, 0, "single");
    endtask

    task automatic test_back_to_back();
        int t0, pp, acc, a5;
        clear_recs();
        tmo_limit_i = '0;
        t0 = cyc;
        do_push(rand_job($urandom_range(0, 15)), 30, pp);
        repeat (3) step();
        for (int i = 0; i < 4; i++)
            do_push(rand_job(i), $urandom_range(1, 12), acc);
        n_chk++;
        if (level_o !== 3'd4 || push_ready_o !== 1'b0)
            $display("FAIL b2b_full: got lvl%0d rdy%b want lvl4 rdy0",
                     level_o, push_ready_o);
        else n_pass++;
        do_push(rand_job(4), $urandom_range(1, 12), a5);
        n_chk++;
        if (a5 !== pp + 37)
            $display("FAIL b2b_stall_accept: got %0d want %0d", a5, pp + 37);
        else n_pass++;
        wait_idle("b2b");
        check_model(t0, 0, "b2b");
    endtask

    task automatic test_watchdog();
        int t0, acc, tmo;
        clear_recs();
        tmo_limit_i = 20'd10;
        t0 = cyc;
        do_push(rand_job(5), 0, acc);
        do_push(rand_job(6), $urandom_range(1, 9), acc);
        wait_idle("wd10");
        check_model(t0, 10, "wd10");
        clear_recs();
        tmo = $urandom_range(3, 12);
        tmo_limit_i = TMO_W'(tmo);
        t0 = cyc;
        for (int i = 0; i < 3; i++)
            do_push(rand_job(i + 7),
                    ($urandom_range(0, 1) == 0) ? 0
                        : $urandom_range(1, tmo - 1), acc);
        wait_idle("wdrnd");
        check_model(t0, tmo, "wdrnd");
    endtask

    task automatic test_no_timeout();
        int acc;
        clear_recs();
        tmo_limit_i = '0;
        do_push(rand_job(9), 0, acc);
        repeat (60) step();
        n_chk++;
        if (hc_q.size() !== 0 || ev_q.size() !== 0 || busy_o !== 1'b1)
            $display("FAIL notmo_hold: got clr%0d evt%0d busy%b want 0 0 1",
                     hc_q.size(), ev_q.size(), busy_o);
        else n_pass++;
        done_q.push_back(cyc + 1);
        repeat (4) step();
        n_chk++;
        if (ev_q.size() !== 1)
            $display("FAIL notmo_evt: got %0d evts want 1", ev_q.size());
        else if (ev_q[0].id !== 4'd9 || ev_q[0].err !== 1'b0)
            $display("FAIL notmo_evt: got id%0d e%b want id9 e0",
                     ev_q[0].id, ev_q[0].err);
        else n_pass++;
        wait_idle("notmo");
    endtask

    task automatic test_collision();
        int t0, acc, tmo;
        clear_recs();
        tmo = $urandom_range(4, 15);
        tmo_limit_i = TMO_W'(tmo);
        t0 = cyc;
        do_push(rand_job(10), tmo - 1, acc);
        do_push(rand_job(11), tmo, acc);
        wait_idle("coll");
        check_model(t0, tmo, "coll");
    endtask

    task automatic test_clear_mid();
        int acc, k;
        clear_recs();
        tmo_limit_i = '0;
        for (int i = 0; i < 3; i++) do_push(rand_job(i + 12), 0, acc);
        k = 0;
        while (st_q.size() == 0 && k < 50) begin step(); k++; end
        repeat (5) step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        n_chk++;
        if (hwpe_clear_o !== 1'b1 || level_o !== 3'd0 || busy_o !== 1'b0 ||
            job_x_addr_o !== '0)
            $display("FAIL clr_state: got clr%b lvl%0d busy%b x%h want 1 0 0 0",
                     hwpe_clear_o, level_o, busy_o, job_x_addr_o);
        else n_pass++;
        repeat (20) step();
        n_chk++;
        if (st_q.size() !== 1 || ev_q.size() !== 0 || hc_q.size() !== 1)
            $display("FAIL clr_after: got st%0d ev%0d clr%0d want 1 0 1",
                     st_q.size(), ev_q.size(), hc_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int acc, k;
        clear_recs();
        tmo_limit_i = '0;
        do_push(rand_job(2), 0, acc);
        do_push(rand_job(3), 0, acc);
        k = 0;
        while (st_q.size() == 0 && k < 50) begin step(); k++; end
        repeat (3) step();
        #2 rst_ni = 1'b0;
        #1;
        n_chk++;
        if (push_ready_o !== 1'b1 || level_o !== 3'd0 || busy_o !== 1'b0 ||
            job_y_addr_o !== '0)
            $display("FAIL arst_async: got rdy%b lvl%0d busy%b y%h want 1 0 0 0",
                     push_ready_o, level_o, busy_o, job_y_addr_o);
        else n_pass++;
        step();
        step();
        rst_ni = 1'b1;
        step();
        n_chk++;
        if (push_ready_o !== 1'b1 || job_start_o !== 1'b0 ||
            evt_o !== 1'b0 || hwpe_clear_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL arst_release: got rdy%b st%b ev%b clr%b busy%b want 1 0 0 0 0",
                     push_ready_o, job_start_o, evt_o, hwpe_clear_o, busy_o);
        else n_pass++;
        done_q.push_back(cyc + 1);
        repeat (5) step();
        n_chk++;
        if (ev_q.size() !== 0 || st_q.size() !== 1)
            $display("FAIL arst_stray_done: got ev%0d st%0d want 0 1",
                     ev_q.size(), st_q.size());
        else n_pass++;
    endtask

    initial begin
        cyc = 0;
        n_chk = 0;
        n_pass = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_watchdog();
        test_no_timeout();
        test_collision();
        test_clear_mid();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
